// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM encodings,
// command payload layout and the illegal-opcode test.
package alu_issue_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_NOT = 4'b0000;
   localparam logic [OP_W-1:0] OP_AND = 4'b0001;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
   localparam logic [OP_W-1:0] OP_DEC = 4'b0100;
   localparam logic [OP_W-1:0] OP_ADD = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
   localparam logic [OP_W-1:0] OP_INC = 4'b0111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // 69-bit command payload; the repeat count travels alongside it
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              use_acc;
   } cmd_payload_t;

   // Any opcode with the top bit set is illegal
   function automatic logic op_illegal(input logic [OP_W-1:0] op);
      return op[OP_W-1];
   endfunction

endpackage

// File: rtl/alu_issue_stage_cmd_fifo2.sv
// Two-entry synchronous command FIFO (payload + repeat count).
// Ports: i_push/i_push_data/i_push_rpt write side; i_pop read side;
//        o_head_c/o_head_rpt_c head entry (valid when !o_empty_c);
//        o_full_c/o_empty_c occupancy flags.
module alu_issue_stage_cmd_fifo2
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_push,
   input  cmd_payload_t       i_push_data,
   input  logic [CNT_W-1:0]   i_push_rpt,
   input  logic               i_pop,
   output cmd_payload_t       o_head_c,
   output logic [CNT_W-1:0]   o_head_rpt_c,
   output logic               o_full_c,
   output logic               o_empty_c
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   cmd_payload_t       r_data [2];
   logic [CNT_W-1:0]   r_rpt  [2];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic               w_push;
   logic               w_pop;

   // A push while full is legal only when the head leaves in the same cycle
   assign w_pop  = i_pop & ~o_empty_c;
   assign w_push = i_push & (~o_full_c | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_rpt[i]  <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_rpt[r_wr_ptr]  <= i_push_rpt;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_c     = r_data[r_rd_ptr];
   assign o_head_rpt_c = r_rpt[r_rd_ptr];
   assign o_full_c     = (r_count == FULL_CNT);
   assign o_empty_c    = (r_count == 2'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// Command-issue stage in front of a combinational 32-bit ALU.
// Ports: cmd_* valid/ready command input (buffered in a 2-entry FIFO);
//        alu_* drive/sample the external ALU; rsp_* valid/ready response
//        output; acc architectural accumulator committed per legal command.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [OP_W-1:0]     cmd_op,
   input  logic [DATA_W-1:0]   cmd_a,
   input  logic [DATA_W-1:0]   cmd_b,
   input  logic                cmd_use_acc,
   input  logic [CNT_W-1:0]    cmd_repeat,
   output logic [OP_W-1:0]     alu_op,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_result,
   input  logic                alu_is0,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_result,
   output logic                rsp_is0,
   output logic                rsp_err,
   output logic [DATA_W-1:0]   acc
);

   logic [1:0]          r_state;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_err;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_result;
   logic                r_rsp_is0;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_acc;

   logic [1:0]          w_nxt_state;
   logic                w_pop;
   logic                w_iter;
   logic                w_done_ok;
   logic                w_done_err;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   cmd_payload_t        w_push_data;
   cmd_payload_t        w_head;
   logic [CNT_W-1:0]    w_head_rpt;
   logic [DATA_W-1:0]   w_load_a;
   logic [CNT_W-1:0]    w_load_cnt;

   assign cmd_ready   = ~w_full;
   assign w_push      = cmd_valid & cmd_ready;
   assign w_push_data = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};

   alu_issue_stage_cmd_fifo2 #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push       (w_push),
      .i_push_data  (w_push_data),
      .i_push_rpt   (cmd_repeat),
      .i_pop        (w_pop),
      .o_head_c     (w_head),
      .o_head_rpt_c (w_head_rpt),
      .o_full_c     (w_full),
      .o_empty_c    (w_empty)
   );

   // Operand a and iteration count captured at pop; acc already holds any
   // result committed on the previous edge, so back-to-back use_acc works
   assign w_load_a   = w_head.use_acc ? r_acc : w_head.a;
   assign w_load_cnt = (w_head_rpt == '0) ? CNT_W'(1) : w_head_rpt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt_state;
   end

   // Next state and control strobes
   always_comb begin
      w_nxt_state = r_state;
      w_pop       = 1'b0;
      w_iter      = 1'b0;
      w_done_ok   = 1'b0;
      w_done_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_nxt_state = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_err) begin
               w_done_err  = 1'b1;
               w_nxt_state = S_RESP;
            end else if (r_cnt > CNT_W'(1)) begin
               w_iter = 1'b1;
            end else begin
               w_done_ok   = 1'b1;
               w_nxt_state = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_nxt_state = S_EXEC;
               end else begin
                  w_nxt_state = S_IDLE;
               end
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Working registers: load on pop, feed the result back while iterating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (w_pop) begin
         r_op  <= w_head.op;
         r_a   <= w_load_a;
         r_b   <= w_head.b;
         r_cnt <= w_load_cnt;
         r_err <= op_illegal(w_head.op);
      end else if (w_iter) begin
         r_a   <= alu_result;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Response and accumulator; fields only change when entering RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_is0    <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_acc        <= '0;
      end else begin
         r_rsp_valid <= (w_nxt_state == S_RESP);
         if (w_done_ok) begin
            r_rsp_result <= alu_result;
            r_rsp_is0    <= alu_is0;
            r_rsp_err    <= 1'b0;
            r_acc        <= alu_result;
         end else if (w_done_err) begin
            r_rsp_result <= '0;
            r_rsp_is0    <= 1'b0;
            r_rsp_err    <= 1'b1;
         end
      end
   end

   assign alu_op     = r_op;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_is0    = r_rsp_is0;
   assign rsp_err    = r_rsp_err;
   assign acc        = r_acc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and a
// command-level reference model (sequential accumulator, plain loops).
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_use_acc;
   logic [7:0]  cmd_repeat;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_is0;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_is0;
   logic        rsp_err;
   logic [31:0] acc;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;
   logic [31:0] model_acc = 32'h0;

   alu_issue_stage #(.DEPTH(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .cmd_repeat(cmd_repeat),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_is0(alu_is0),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_is0(rsp_is0), .rsp_err(rsp_err), .acc(acc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return ~a;
         4'd1: return a & b;
         4'd2: return a ^ b;
         4'd3: return a | b;
         4'd4: return a - 32'd1;
         4'd5: return a + b;
         4'd6: return a - b;
         4'd7: return a + 32'd1;
         default: return 32'h0;
      endcase
   endfunction

   // External combinational ALU
   always_comb begin
      alu_result = alu_f(alu_op, alu_a, alu_b);
      alu_is0    = (alu_result == 32'h0);
   end

   // Whole-command reference: iterate the op N times, commit to acc if legal
   task automatic model_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic ua, input logic [7:0] rpt,
                            output logic [31:0] res, output logic is0, output logic err);
      logic [31:0] x;
      int n;
      if (op >= 4'd8) begin
         res = 32'h0; is0 = 1'b0; err = 1'b1;
      end else begin
         x = ua ? model_acc : a;
         n = (rpt == 8'd0) ? 1 : int'(rpt);
         for (int i = 0; i < n; i++) x = alu_f(op, x, b);
         res = x; is0 = (x == 32'h0); err = 1'b0;
         model_acc = x;
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ua, input logic [7:0] rpt);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_repeat = rpt; cmd_valid = 1'b1;
   endtask

   // Issue one command with rsp_ready=1; lat = cycles from accept to rsp_valid
   task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ua, input logic [7:0] rpt,
                         output logic [31:0] res, output logic is0, output logic err, output int lat);
      bit ok = 0;
      res = 32'h0; is0 = 1'b0; err = 1'b0; lat = -1;
      rsp_ready = 1'b1;
      set_cmd(op, a, b, ua, rpt);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      if (ok) begin
         for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
               res = rsp_result; is0 = rsp_is0; err = rsp_err; lat = k;
               break;
            end
         end
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 32'h0; cmd_b = 32'h0;
      cmd_use_acc = 1'b0; cmd_repeat = 8'h0; rsp_ready = 1'b0;
      repeat (3) tick();
      n_tot++; if ({cmd_ready, rsp_valid, rsp_is0, rsp_err} !== 4'b1000)
         $display("FAIL reset_flags: got rdy/vld/is0/err=%b want 1000", {cmd_ready, rsp_valid, rsp_is0, rsp_err}); else n_pass++;
      n_tot++; if (rsp_result !== 32'h0) $display("FAIL reset_result: got %h want 0", rsp_result); else n_pass++;
      n_tot++; if (acc !== 32'h0) $display("FAIL reset_acc: got %h want 0", acc); else n_pass++;
      n_tot++; if ({alu_op, alu_a, alu_b} !== 68'h0)
         $display("FAIL reset_alu_drive: got op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b); else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   // ADD then back-to-back INC using acc, repeated 4 times
   task automatic test_add_then_inc_chain();
      logic        rv  [12];
      logic [3:0]  opl [12];
      logic [31:0] al  [12];
      logic [31:0] rl  [12];
      logic [31:0] accl[12];
      logic [1:0]  fl  [12];
      logic [31:0] e1, e2, av;
      logic ez, ee;
      int first = -1, second = -1;
      model_cmd(4'd5, 32'd5, 32'd7, 1'b0, 8'd1, e1, ez, ee);
      model_cmd(4'd7, 32'hDEADBEEF, 32'd0, 1'b1, 8'd4, e2, ez, ee);
      rsp_ready = 1'b1;
      fork
         begin
            set_cmd(4'd5, 32'd5, 32'd7, 1'b0, 8'd1); tick();
            set_cmd(4'd7, 32'hDEADBEEF, 32'd0, 1'b1, 8'd4); tick();
            cmd_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 12; k++) begin
               @(negedge clk);
               rv[k] = rsp_valid; opl[k] = alu_op; al[k] = alu_a;
               rl[k] = rsp_result; accl[k] = acc; fl[k] = {rsp_is0, rsp_err};
            end
         end
      join
      tick();
      for (int k = 0; k < 12; k++) begin
         if (rv[k] === 1'b1 && first < 0) first = k;
         else if (rv[k] === 1'b1 && first >= 0 && second < 0) second = k;
      end
      n_tot++; if (first !== 3) $display("FAIL add_latency: rsp_valid at cycle %0d want 3", first); else n_pass++;
      n_tot++; if (opl[2] !== 4'd5 || al[2] !== 32'd5)
         $display("FAIL add_drive: op=%h a=%h want op=5 a=5", opl[2], al[2]); else n_pass++;
      n_tot++; if (rl[3] !== e1 || fl[3] !== 2'b00)
         $display("FAIL add_result: got %h is0/err=%b want %h 00", rl[3], fl[3], e1); else n_pass++;
      n_tot++; if (accl[3] !== e1) $display("FAIL add_acc: got %h want %h", accl[3], e1); else n_pass++;
      av = 32'd12;
      for (int k = 4; k < 8; k++) begin
         n_tot++; if (al[k] !== av) $display("FAIL inc_alu_a[%0d]: got %h want %h", k, al[k], av); else n_pass++;
         av = av + 32'd1;
      end
      n_tot++; if (second !== 8) $display("FAIL inc_back_to_back: rsp_valid at cycle %0d want 8", second); else n_pass++;
      n_tot++; if (rl[8] !== e2 || accl[8] !== e2)
         $display("FAIL inc_result: got res=%h acc=%h want %h", rl[8], accl[8], e2); else n_pass++;
   endtask

   // Zero flag, wrap-around and illegal opcode boundaries
   task automatic test_flags_and_illegal();
      logic [31:0] r, er; logic z, ez, e, ee; int lat; logic [31:0] acc_before;
      model_cmd(4'd6, 32'd3, 32'd3, 1'b0, 8'd1, er, ez, ee);
      do_cmd(4'd6, 32'd3, 32'd3, 1'b0, 8'd1, r, z, e, lat);
      n_tot++; if ({r, z, e} !== {er, ez, ee} || ez !== 1'b1)
         $display("FAIL sub_zero: got %h is0=%b err=%b want %h is0=1 err=0", r, z, e, er); else n_pass++;
      model_cmd(4'd4, 32'd0, 32'd0, 1'b0, 8'd1, er, ez, ee);
      do_cmd(4'd4, 32'd0, 32'd0, 1'b0, 8'd1, r, z, e, lat);
      n_tot++; if ({r, z, e} !== {er, ez, ee})
         $display("FAIL dec_wrap: got %h is0=%b err=%b want %h is0=%b", r, z, e, er, ez); else n_pass++;
      acc_before = model_acc;
      model_cmd(4'b1000, 32'd77, 32'd1, 1'b0, 8'd9, er, ez, ee);
      do_cmd(4'b1000, 32'd77, 32'd1, 1'b0, 8'd9, r, z, e, lat);
      n_tot++; if (lat !== 3) $display("FAIL illegal_one_exec: latency %0d want 3", lat); else n_pass++;
      n_tot++; if ({r, z, e} !== {er, ez, ee})
         $display("FAIL illegal_rsp: got %h is0=%b err=%b want 0 0 1", r, z, e); else n_pass++;
      n_tot++; if (acc !== acc_before) $display("FAIL illegal_acc: got %h want %h", acc, acc_before); else n_pass++;
   endtask

   // Hold rsp_ready low with four commands queued, then drain
   task automatic test_backpressure();
      logic [3:0]  op[4]; logic [31:0] a[4], b[4]; logic ua[4]; logic [7:0] rp[4];
      logic [31:0] er[4]; logic ez[4], ee[4];
      int t[4];
      int bad_hold = 0, bad_rdy = 0;
      bit ok4 = 0;
      for (int i = 0; i < 4; i++) begin
         op[i] = 4'($urandom_range(0, 7)); a[i] = $urandom(); b[i] = $urandom();
         ua[i] = 1'($urandom_range(0, 1)); rp[i] = 8'($urandom_range(1, 3));
         model_cmd(op[i], a[i], b[i], ua[i], rp[i], er[i], ez[i], ee[i]);
      end
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_cmd(op[i], a[i], b[i], ua[i], rp[i]);
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) begin tick(); break; end
            tick();
         end
      end
      set_cmd(op[3], a[3], b[3], ua[3], rp[3]);
      repeat (8) tick();
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (!(rsp_valid === 1'b1 && rsp_result === er[0] && rsp_is0 === ez[0] && rsp_err === ee[0])) bad_hold++;
         if (cmd_ready !== 1'b0) bad_rdy++;
      end
      tick();
      n_tot++; if (bad_hold != 0) $display("FAIL bp_hold: %0d cycles with unstable first response (want %h)", bad_hold, er[0]); else n_pass++;
      n_tot++; if (bad_rdy != 0) $display("FAIL bp_cmd_ready: high in %0d cycles, want low with 2 buffered", bad_rdy); else n_pass++;
      rsp_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               @(negedge clk);
               if (cmd_ready) begin ok4 = 1; tick(); break; end
               tick();
            end
            cmd_valid = 1'b0;
         end
         begin
            int got = 0;
            for (int k = 0; k < 200 && got < 4; k++) begin
               @(negedge clk);
               if (rsp_valid) begin
                  t[got] = cyc;
                  n_tot++; if ({rsp_result, rsp_is0, rsp_err} !== {er[got], ez[got], ee[got]})
                     $display("FAIL bp_rsp%0d: got %h/%b/%b want %h/%b/%b", got, rsp_result, rsp_is0, rsp_err, er[got], ez[got], ee[got]);
                  else n_pass++;
                  got++;
               end
            end
            n_tot++; if (got != 4) $display("FAIL bp_drain: got %0d responses want 4", got); else n_pass++;
            for (int i = 1; i < got; i++) begin
               n_tot++; if (t[i] - t[i-1] != int'(rp[i]) + 1)
                  $display("FAIL bp_gap%0d: %0d cycles want %0d", i, t[i] - t[i-1], int'(rp[i]) + 1); else n_pass++;
            end
         end
      join
      n_tot++; if (!ok4) $display("FAIL bp_cmd4_accept: 4th command never accepted, want accepted"); else n_pass++;
      tick();
   endtask

   // Random commands, random gaps and random rsp_ready against the model
   task automatic test_random();
      localparam int NR = 40;
      logic [31:0] q_res[$]; logic q_is0[$]; logic q_err[$];
      bit drv_ok = 1;
      int got = 0;
      fork
         begin
            for (int i = 0; i < NR && drv_ok; i++) begin
               logic [3:0] op; logic [31:0] a, b; logic ua; logic [7:0] rp;
               logic [31:0] r; logic z, e;
               bit ok = 0;
               cmd_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
               op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
               a = $urandom(); b = ($urandom_range(0, 5) == 0) ? a : $urandom();
               ua = 1'($urandom_range(0, 1)); rp = 8'($urandom_range(0, 4));
               set_cmd(op, a, b, ua, rp);
               for (int k = 0; k < 300; k++) begin
                  @(negedge clk);
                  if (cmd_ready) begin
                     ok = 1;
                     @(posedge clk);
                     model_cmd(op, a, b, ua, rp, r, z, e);
                     q_res.push_back(r); q_is0.push_back(z); q_err.push_back(e);
                     #1;
                     break;
                  end
                  tick();
               end
               if (!ok) drv_ok = 0;
            end
            cmd_valid = 1'b0;
         end
         begin
            logic pv = 1'b0, pr = 1'b0; logic [31:0] hr = 32'h0; logic hz = 1'b0, he = 1'b0;
            int guard = 0;
            while (got < NR && guard < 6000) begin
               rsp_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk); guard++;
               if (pv && !pr) begin
                  n_tot++; if ({rsp_valid, rsp_result, rsp_is0, rsp_err} !== {1'b1, hr, hz, he})
                     $display("FAIL rnd_stable: got v=%b %h/%b/%b want v=1 %h/%b/%b", rsp_valid, rsp_result, rsp_is0, rsp_err, hr, hz, he);
                  else n_pass++;
               end
               if (rsp_valid && rsp_ready) begin
                  n_tot++;
                  if (q_res.size() == 0) $display("FAIL rnd_unexpected: response %h with nothing outstanding", rsp_result);
                  else begin
                     if ({rsp_result, rsp_is0, rsp_err} !== {q_res[0], q_is0[0], q_err[0]})
                        $display("FAIL rnd_rsp%0d: got %h/%b/%b want %h/%b/%b", got, rsp_result, rsp_is0, rsp_err, q_res[0], q_is0[0], q_err[0]);
                     else n_pass++;
                     void'(q_res.pop_front()); void'(q_is0.pop_front()); void'(q_err.pop_front());
                  end
                  got++;
               end
               pv = rsp_valid; pr = rsp_ready; hr = rsp_result; hz = rsp_is0; he = rsp_err;
               tick();
            end
         end
      join
      n_tot++; if (got != NR || !drv_ok) $display("FAIL rnd_complete: %0d responses want %0d (driver ok=%0d)", got, NR, drv_ok); else n_pass++;
      n_tot++; if (acc !== model_acc) $display("FAIL rnd_acc: got %h want %h", acc, model_acc); else n_pass++;
      rsp_ready = 1'b1;
   endtask

   // Reset asserted during a long EXEC with another command buffered
   task automatic test_reset_mid_exec();
      logic [31:0] r, er; logic z, ez, e, ee; int lat; int stale = 0;
      model_cmd(4'd5, 32'd1, 32'd1, 1'b0, 8'd1, er, ez, ee);
      do_cmd(4'd5, 32'd1, 32'd1, 1'b0, 8'd1, r, z, e, lat);
      rsp_ready = 1'b1;
      set_cmd(4'd5, 32'd1, 32'd2, 1'b1, 8'd10); tick();
      set_cmd(4'd3, 32'd9, 32'd6, 1'b0, 8'd1); tick();
      cmd_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      model_acc = 32'h0;
      n_tot++; if ({rsp_valid, cmd_ready} !== 2'b01)
         $display("FAIL rst_mid_flags: got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, cmd_ready); else n_pass++;
      n_tot++; if (acc !== 32'h0) $display("FAIL rst_mid_acc: got %h want 0", acc); else n_pass++;
      n_tot++; if ({alu_op, alu_a} !== 36'h0) $display("FAIL rst_mid_alu: got op=%h a=%h want 0", alu_op, alu_a); else n_pass++;
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) stale++;
      end
      tick();
      n_tot++; if (stale != 0) $display("FAIL rst_no_stale: rsp_valid high %0d cycles want 0", stale); else n_pass++;
      model_cmd(4'd5, 32'hFFFF0000, 32'd5, 1'b1, 8'd0, er, ez, ee);
      do_cmd(4'd5, 32'hFFFF0000, 32'd5, 1'b1, 8'd0, r, z, e, lat);
      n_tot++; if (r !== er || lat !== 3)
         $display("FAIL rst_acc_reuse: got %h lat=%0d want %h lat=3", r, lat, er); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_add_then_inc_chain();
      test_flags_and_illegal();
      test_backpressure();
      test_random();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
